multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 75 +++++++
 rtl/multicycle_control_alu_decoder.sv | 25 ++
 rtl/multicycle_control.sv | 167 ++++++++++++++++
 tb/tb_multicycle_control.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS-style controller: state encodings,
// opcode/funct constants, ALU operation codes and the control-word layout.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_control;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // True for every opcode DECODE knows how to dispatch.
    function automatic logic opcode_known(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) ||
               (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct field to ALU operation decoder; unknown functs fall back to AND
// and raise illegal_funct.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       illegal_funct
);

    always_comb begin
        alu_control   = ALU_AND;
        illegal_funct = 1'b0;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_NOR:  alu_control = ALU_NOR;
            FN_SLT:  alu_control = ALU_SLT;
            default: illegal_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller FSM: sequences fetch/decode/execute/writeback and drives
// the datapath selects and strobes combinationally from the registered state.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_control,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl;
    logic [3:0] r_alu_control;
    logic       illegal_funct;

    alu_decoder u_alu_decoder (
        .funct         (funct),
        .alu_control   (r_alu_control),
        .illegal_funct (illegal_funct)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Unused encodings 12-15 land in the default arm and recover to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = S_R_EX;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDI_EX;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EX:     state_d = illegal_funct ? S_FETCH : S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read    = 1'b1;
                ctrl.alu_src_b   = SRCB_FOUR;
                ctrl.alu_control = ALU_ADD;
                ctrl.pc_source   = PCSRC_ALU;
                ctrl.ir_write    = mem_ready;
                ctrl.pc_en       = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b   = SRCB_IMMSH;
                ctrl.alu_control = ALU_ADD;
                ctrl.illegal     = ~opcode_known(opcode);
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_IMM;
                ctrl.alu_control = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.iord       = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_R_EX: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_REG;
                ctrl.alu_control = r_alu_control;
                ctrl.illegal     = illegal_funct;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_REG;
                ctrl.alu_control = ALU_SUB;
                ctrl.pc_source   = PCSRC_ALUOUT;
                ctrl.pc_en       = (opcode == OP_BNE) ? ~zero : zero;
                ctrl.instr_done  = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.pc_en      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_IMM;
                ctrl.alu_control = ALU_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Reset suppresses every strobe asynchronously; selects keep FETCH values.
    assign pc_en       = ctrl.pc_en      & ~reset;
    assign ir_write    = ctrl.ir_write   & ~reset;
    assign mem_write   = ctrl.mem_write  & ~reset;
    assign reg_write   = ctrl.reg_write  & ~reset;
    assign instr_done  = ctrl.instr_done & ~reset;
    assign illegal     = ctrl.illegal    & ~reset;
    assign iord        = ctrl.iord;
    assign mem_read    = ctrl.mem_read;
    assign reg_dst     = ctrl.reg_dst;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign pc_source   = ctrl.pc_source;
    assign alu_control = ctrl.alu_control;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each issued instruction pushes its
// hand-computed retirement summary; a negedge monitor pops it on each pulse.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_control;
    logic       instr_done, illegal;
    logic [3:0] state;

    typedef struct {
        bit [1:0] pulse;
        int       cycles;
        int       fstate;
        int       mw;
        int       rw;
        int       pce;
        int       pcs;
        int       alu;
        int       wb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_source   (pc_source),
        .alu_control (alu_control),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    function automatic exp_t mk(bit [1:0] pulse, int cycles, int fstate, int mw, int rw,
                                int pce, int pcs, int alu, int wb);
        exp_t e;
        e.pulse = pulse; e.cycles = cycles; e.fstate = fstate; e.mw = mw; e.rw = rw;
        e.pce = pce; e.pcs = pcs; e.alu = alu; e.wb = wb;
        return e;
    endfunction

    // Drives one instruction for ncyc cycles, mem_ready following pat bit by bit.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input logic [15:0] pat, input int ncyc, input exp_t e);
        opcode = op;
        funct  = fn;
        zero   = z;
        exp_q.push_back(e);
        for (int i = 0; i < ncyc; i++) begin
            mem_ready = pat[i];
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: accumulates per-instruction observations, compares on each pulse.
    int cyc = 0, mw_cnt = 0, rw_cnt = 0, last_alu = 15, wb_sel = -1, instr_idx = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                cyc = 0; mw_cnt = 0; rw_cnt = 0; last_alu = 15; wb_sel = -1;
            end else begin
                cyc++;
                if (mem_write) mw_cnt++;
                if (reg_write) begin
                    rw_cnt++;
                    wb_sel = {30'd0, reg_dst, mem_to_reg};
                end
                if (mem_write && reg_write)
                    checkOutput("mem_write_and_reg_write", 1, 0);
                if (state == 4'd2 || state == 4'd6 || state == 4'd8 || state == 4'd10)
                    last_alu = int'(alu_control);
                if (instr_done || illegal) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_pulse", int'(state), -1);
                    end else begin
                        exp_t e;
                        string p;
                        e = exp_q.pop_front();
                        p = $sformatf("instr%0d_", instr_idx);
                        checkOutput({p, "pulse"}, int'({illegal, instr_done}), int'(e.pulse));
                        checkOutput({p, "cycles"}, cyc, e.cycles);
                        checkOutput({p, "final_state"}, int'(state), e.fstate);
                        checkOutput({p, "mem_write_cycles"}, mw_cnt, e.mw);
                        checkOutput({p, "reg_write_cycles"}, rw_cnt, e.rw);
                        checkOutput({p, "pc_en"}, int'(pc_en), e.pce);
                        checkOutput({p, "pc_source"}, int'(pc_source), e.pcs);
                        checkOutput({p, "alu_control"}, last_alu, e.alu);
                        checkOutput({p, "wb_select"}, wb_sel, e.wb);
                    end
                    instr_idx++;
                    cyc = 0; mw_cnt = 0; rw_cnt = 0; last_alu = 15; wb_sel = -1;
                end
            end
        end
    end

    localparam logic [15:0] ALL1 = 16'hFFFF;

    initial begin
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
        #3;
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_mem_read", int'(mem_read), 1);
        checkOutput("reset_alu_src_b", int'(alu_src_b), 1);
        checkOutput("reset_alu_control", int'(alu_control), 2);
        mem_ready = 1'b1;
        #1;
        checkOutput("reset_ir_write", int'(ir_write), 0);
        checkOutput("reset_pc_en", int'(pc_en), 0);
        @(posedge clk);
        #1;
        checkOutput("reset_hold_state", int'(state), 0);
        reset = 1'b0;

        // {illegal,instr_done}, cycles, final state, mw, rw, pc_en, pc_source, alu, wb
        applyStimulus(6'h00, 6'h20, 1'b0, ALL1, 4, mk(2'b01, 4, 7, 0, 1, 0, 0, 2, 2));
        applyStimulus(6'h00, 6'h22, 1'b0, ALL1, 4, mk(2'b01, 4, 7, 0, 1, 0, 0, 6, 2));
        applyStimulus(6'h00, 6'h2A, 1'b0, ALL1, 4, mk(2'b01, 4, 7, 0, 1, 0, 0, 7, 2));
        applyStimulus(6'h00, 6'h27, 1'b0, ALL1, 4, mk(2'b01, 4, 7, 0, 1, 0, 0, 10, 2));
        applyStimulus(6'h00, 6'h25, 1'b0, ALL1, 4, mk(2'b01, 4, 7, 0, 1, 0, 0, 1, 2));
        applyStimulus(6'h00, 6'h24, 1'b0, ALL1, 4, mk(2'b01, 4, 7, 0, 1, 0, 0, 0, 2));
        // lw: two wait cycles in MEM_RD
        applyStimulus(6'h23, 6'h00, 1'b0, 16'h0067, 7, mk(2'b01, 7, 4, 0, 1, 0, 0, 2, 1));
        // lw: one wait cycle in FETCH
        applyStimulus(6'h23, 6'h00, 1'b0, 16'h003E, 6, mk(2'b01, 6, 4, 0, 1, 0, 0, 2, 1));
        // sw then j back to back
        applyStimulus(6'h2B, 6'h00, 1'b0, ALL1, 4, mk(2'b01, 4, 5, 1, 0, 0, 0, 2, -1));
        applyStimulus(6'h02, 6'h00, 1'b0, ALL1, 3, mk(2'b01, 3, 9, 0, 0, 1, 2, 15, -1));
        applyStimulus(6'h04, 6'h00, 1'b1, ALL1, 3, mk(2'b01, 3, 8, 0, 0, 1, 1, 6, -1));
        applyStimulus(6'h05, 6'h00, 1'b1, ALL1, 3, mk(2'b01, 3, 8, 0, 0, 0, 1, 6, -1));
        applyStimulus(6'h04, 6'h00, 1'b0, ALL1, 3, mk(2'b01, 3, 8, 0, 0, 0, 1, 6, -1));
        applyStimulus(6'h05, 6'h00, 1'b0, ALL1, 3, mk(2'b01, 3, 8, 0, 0, 1, 1, 6, -1));
        applyStimulus(6'h08, 6'h00, 1'b0, ALL1, 4, mk(2'b01, 4, 11, 0, 1, 0, 0, 2, 0));
        applyStimulus(6'h3F, 6'h00, 1'b0, ALL1, 2, mk(2'b10, 2, 1, 0, 0, 0, 0, 15, -1));
        applyStimulus(6'h00, 6'h3F, 1'b0, ALL1, 3, mk(2'b10, 3, 6, 0, 0, 0, 0, 0, -1));
        // sw with two wait cycles in MEM_WR
        applyStimulus(6'h2B, 6'h00, 1'b0, 16'h0027, 6, mk(2'b01, 6, 5, 3, 0, 0, 0, 2, -1));

        // Abandon a store mid-wait with an asynchronous reset.
        opcode = 6'h2B; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        checkOutput("pre_reset_state_mem_wr", int'(state), 5);
        checkOutput("pre_reset_mem_write", int'(mem_write), 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_state", int'(state), 0);
        checkOutput("async_reset_mem_write", int'(mem_write), 0);
        checkOutput("async_reset_instr_done", int'(instr_done), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(6'h00, 6'h20, 1'b0, ALL1, 4, mk(2'b01, 4, 7, 0, 1, 0, 0, 2, 2));

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
